// File: rtl/up_down_counter_pkg.sv
// Shared constants for the up/down counter: direction encoding, default width,
// and the full-scale helper used to derive the default terminal count.
package up_down_counter_pkg;

    localparam int unsigned DEFAULT_WIDTH = 4;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Largest value representable in w bits; computed in 64 bits so w = 32 is safe.
    function automatic int unsigned full_scale(input int unsigned w);
        return 32'((64'd1 << w) - 64'd1);
    endfunction

endpackage

// File: rtl/up_down_counter_step.sv
// Combinational next-value logic: steps the count up or down modulo (MAX_VALUE+1).
module up_down_counter_step
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_VALUE = full_scale(WIDTH)
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_updown,
    output logic [WIDTH-1:0] o_count_next
);

    localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX_VALUE);

    logic w_at_max;
    logic w_at_zero;
    logic w_out_of_range;

    assign w_at_max       = (i_count == MaxVal);
    assign w_at_zero      = (i_count == '0);
    assign w_out_of_range = (i_count > MaxVal);

    always_comb begin
        o_count_next = '0;
        // A value above the terminal count can only come from a fault; recover to 0.
        if (w_out_of_range) begin
            o_count_next = '0;
        end else if (i_updown == DIR_UP) begin
            o_count_next = w_at_max ? '0 : i_count + WIDTH'(1);
        end else begin
            o_count_next = w_at_zero ? MaxVal : i_count - WIDTH'(1);
        end
    end

endmodule

// File: rtl/up_down_counter.sv
// Up/down wrapping counter: a single state register with asynchronous active-low
// reset; the step logic lives in up_down_counter_step.
module up_down_counter
    import up_down_counter_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned MAX_VALUE = full_scale(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             updown,
    output logic [WIDTH-1:0] count
);

    localparam longint unsigned FullScale = (64'd1 << WIDTH) - 64'd1;

    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("up_down_counter: WIDTH=%0d outside 1..32", WIDTH);
    end

    if (MAX_VALUE < 1 || 64'(MAX_VALUE) > FullScale) begin : g_bad_max
        $error("up_down_counter: MAX_VALUE=%0d outside 1..2**WIDTH-1", MAX_VALUE);
    end

    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] w_count_next;

    up_down_counter_step #(
        .WIDTH    (WIDTH),
        .MAX_VALUE(MAX_VALUE)
    ) u_step (
        .i_count     (r_count),
        .i_updown    (updown),
        .o_count_next(w_count_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_next;
        end
    end

    assign count = r_count;

endmodule

// File: tb/tb_up_down_counter.sv
// Scoreboard bench: driver pushes modulo-arithmetic expectations, monitor pops and
// compares after each rising edge; default-parameter and MAX_VALUE=9 DUTs run together.
module tb_up_down_counter;

    localparam int unsigned MaxA = 15;
    localparam int unsigned MaxB = 9;

    typedef struct {
        int unsigned exp_a;
        int unsigned exp_b;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       updown;
    logic [3:0] count_a;
    logic [3:0] count_b;

    exp_t        sb_q[$];
    int unsigned n_vec;
    int unsigned n_fail;
    int unsigned m_a;
    int unsigned m_b;

    up_down_counter u_dut_a (
        .clk   (clk),
        .rst   (rst),
        .updown(updown),
        .count (count_a)
    );

    up_down_counter #(
        .WIDTH    (4),
        .MAX_VALUE(9)
    ) u_dut_b (
        .clk   (clk),
        .rst   (rst),
        .updown(updown),
        .count (count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned model_next(input int unsigned c, input logic up,
                                               input int unsigned m);
        return up ? (c + 1) % (m + 1) : (c + m) % (m + 1);
    endfunction

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and queue what the next rising edge should produce.
    task automatic drive_cycle(input logic r, input logic up);
        exp_t e;
        rst    = r;
        updown = up;
        if (!r) begin
            m_a = 0;
            m_b = 0;
        end else begin
            m_a = model_next(m_a, up, MaxA);
            m_b = model_next(m_b, up, MaxB);
        end
        e.exp_a = m_a;
        e.exp_b = m_b;
        sb_q.push_back(e);
        @(negedge clk);
    endtask

    // Monitor: one expectation per rising edge, sampled 1 ns after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check("count_default", 32'(count_a), e.exp_a);
                check("count_max9", 32'(count_b), e.exp_b);
                check("max9_bound", 32'(count_b > 4'd9), 0);
            end
        end
    end

    initial begin
        exp_t e;
        int   guard;
        n_vec  = 0;
        n_fail = 0;
        m_a    = 0;
        m_b    = 0;
        rst    = 1'b1;
        updown = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("reset_before_clk_a", 32'(count_a), 0);
        check("reset_before_clk_b", 32'(count_b), 0);

        repeat (15) drive_cycle(1'b0, 1'b0);
        repeat (17) drive_cycle(1'b1, 1'b1);
        repeat (15) drive_cycle(1'b1, 1'b0);
        repeat (15) drive_cycle(1'b1, 1'b1);

        guard = 0;
        while (m_a != 9 && guard < 32) begin
            drive_cycle(1'b1, 1'b1);
            guard++;
        end
        check("reach_nine", m_a, 9);

        // Mid-cycle asynchronous reset at count 9, then release counting down.
        #2 rst = 1'b0;
        #1;
        check("async_clear_a", 32'(count_a), 0);
        check("async_clear_b", 32'(count_b), 0);
        m_a = 0;
        m_b = 0;
        e.exp_a = 0;
        e.exp_b = 0;
        sb_q.push_back(e);
        @(negedge clk);
        drive_cycle(1'b0, 1'b0);
        drive_cycle(1'b1, 1'b0);
        check("release_down_a", m_a, MaxA);

        for (int i = 0; i < 400; i++) begin
            drive_cycle(($urandom_range(39) == 0) ? 1'b0 : 1'b1, 1'($urandom_range(1)));
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
